// File: rtl/frame_snapshot_mux.sv
// Snapshot bank for decoded frames, read byte-wise by the MCU over an 8-bit port.
// Freeze holds the snapshot stable; frames arriving meanwhile park in a one-deep pending buffer.
module frame_snapshot_mux #(
    parameter int FRAME_BYTES  = 12,
    parameter int ADDR_WIDTH   = 4,
    parameter int STATUS_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     frame_valid,
    input  logic [FRAME_BYTES*8-1:0] frame_data,
    input  logic [STATUS_WIDTH-1:0]  frame_status,
    input  logic                     freeze,
    input  logic                     ack,
    input  logic                     addr_mode,
    input  logic [ADDR_WIDTH-1:0]    address,
    input  logic                     rd_strobe,
    output logic [7:0]               parallel_out,
    output logic                     full,
    output logic                     overrun
);

    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(FRAME_BYTES - 1);

    logic [FRAME_BYTES*8-1:0] snapshot;
    logic [STATUS_WIDTH-1:0]  snap_status;
    logic [FRAME_BYTES*8-1:0] pending;
    logic [STATUS_WIDTH-1:0]  pend_status;
    logic                     pending_valid;
    logic [ADDR_WIDTH-1:0]    ptr;

    logic                     load_frame;
    logic                     load_pend;
    logic                     hold_frame;
    logic                     load;
    logic                     full_next;
    logic                     overrun_next;
    logic [ADDR_WIDTH-1:0]    ptr_next;
    logic [ADDR_WIDTH-1:0]    sel;
    logic [3:0]               status_low;
    logic [7:0]               rd_byte;

    // ack clears first, so a load in the same cycle sees full as already consumed
    always_comb begin
        load_frame   = !freeze && frame_valid;
        load_pend    = !freeze && !frame_valid && pending_valid;
        hold_frame   = freeze && frame_valid;
        load         = load_frame || load_pend;
        full_next    = full;
        overrun_next = overrun;
        if (ack) begin
            full_next    = 1'b0;
            overrun_next = 1'b0;
        end
        if (load) begin
            full_next = 1'b1;
            if (full && !ack) begin
                overrun_next = 1'b1;
            end
        end
        if ((load_frame || hold_frame) && pending_valid) begin
            overrun_next = 1'b1;
        end
    end

    // Pointer walks payload bytes, then the status register, then wraps
    always_comb begin
        ptr_next = ptr;
        if (load || ack) begin
            ptr_next = '0;
        end else if (addr_mode && rd_strobe) begin
            if (ptr == LAST_ADDR) begin
                ptr_next = STATUS_ADDR;
            end else if (ptr == STATUS_ADDR) begin
                ptr_next = '0;
            end else begin
                ptr_next = ptr + 1'b1;
            end
        end
    end

    always_comb begin
        sel        = addr_mode ? ptr : address;
        status_low = '0;
        status_low[STATUS_WIDTH-1:0] = snap_status;
        rd_byte    = 8'h00;
        if (sel == STATUS_ADDR) begin
            rd_byte = {overrun, pending_valid, full, freeze, status_low};
        end else begin
            for (int k = 0; k < FRAME_BYTES; k++) begin
                if (sel == ADDR_WIDTH'(k)) begin
                    rd_byte = snapshot[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            snapshot      <= '0;
            snap_status   <= '0;
            pending       <= '0;
            pend_status   <= '0;
            pending_valid <= 1'b0;
            full          <= 1'b0;
            overrun       <= 1'b0;
            ptr           <= '0;
            parallel_out  <= 8'h00;
        end else begin
            full         <= full_next;
            overrun      <= overrun_next;
            ptr          <= ptr_next;
            parallel_out <= rd_byte;
            if (load_frame) begin
                snapshot    <= frame_data;
                snap_status <= frame_status;
            end else if (load_pend) begin
                snapshot    <= pending;
                snap_status <= pend_status;
            end
            if (hold_frame) begin
                pending     <= frame_data;
                pend_status <= frame_status;
            end
            if (load) begin
                pending_valid <= 1'b0;
            end else if (hold_frame) begin
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/frame_snapshot_mux.md
Name: frame_snapshot_mux

Overview:
- Parametrised successor to the decoded-packet byte multiplexer.
- Captures each complete decoded frame from the serial decoder into a snapshot bank, which the microcontroller reads one byte at a time over an 8-bit parallel port.
- Adds freeze control so RX data cannot change during a read, a one-deep pending buffer, sticky overrun detection, an acknowledge handshake, an auto-increment read pointer and registered output.

Parameters:
FRAME_BYTES, 12, number of payload bytes per decoded frame (legal 1..2^ADDR_WIDTH-1)
ADDR_WIDTH, 4, width of byte address; top address 2^ADDR_WIDTH-1 is the status register
STATUS_WIDTH, 4, width of decoder validation flags (legal 1..4)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
frame_valid  input  1  one-cycle pulse; frame_data/frame_status valid this cycle
frame_data  input  FRAME_BYTES*8  decoded frame, byte k = bits [8k+7:8k]
frame_status  input  STATUS_WIDTH  decoder validation flags for this frame
freeze  input  1  level; 1 = snapshot must not change
ack  input  1  one-cycle pulse; MCU has consumed the snapshot
addr_mode  input  1  0 = use address port, 1 = use internal read pointer
address  input  ADDR_WIDTH  byte select when addr_mode=0
rd_strobe  input  1  one-cycle pulse; advances read pointer when addr_mode=1
parallel_out  output  8  selected byte, registered
full  output  1  snapshot holds unacknowledged frame
overrun  output  1  sticky; an unacknowledged frame was lost or overwritten

Behaviour:
- Reset (reset_n=0 at clock edge): snapshot, pending, status copies = 0; pending_valid=0; full=0; overrun=0; read pointer=0; parallel_out=0x00.
- Byte select sel = address (addr_mode=0) or pointer (addr_mode=1).
  - sel < FRAME_BYTES -> snapshot byte sel.
  - sel = 2^ADDR_WIDTH-1 -> status byte {overrun, pending_valid, full, freeze, zero-extended snapshot status to 4 bits}.
  - All other addresses -> 0x00.
- parallel_out is registered from sel and reflects state one cycle after address change (1-cycle latency); status byte shows pre-edge flag values.
- Snapshot update, per cycle, priority order:
  1. ack: full<=0, overrun<=0 (ack applied before load in same cycle).
  2. freeze=0 and frame_valid: snapshot<=frame; full<=1. If full was 1 and no ack this cycle, overrun<=1. If pending_valid=1, pending is discarded, pending_valid<=0, overrun<=1.
  3. freeze=0, no frame_valid, pending_valid=1: snapshot<=pending; pending_valid<=0; full<=1; overrun<=1 if full was 1 without ack.
  4. freeze=1 and frame_valid: pending<=frame; pending_valid<=1. If pending_valid was already 1, overrun<=1 (newest wins). Snapshot, full unchanged.
- Any snapshot load resets the pointer to 0. ack also resets the pointer to 0.
- Pointer, addr_mode=1: rd_strobe increments it; after FRAME_BYTES-1 it goes to 2^ADDR_WIDTH-1 (status), then wraps to 0.
  - rd_strobe with addr_mode=0 is ignored.
  - If a load and rd_strobe occur in the same cycle, the load reset wins.
- freeze does not block ack, pointer movement or reads.
- Reset mid-frame or mid-read discards everything; no partial state survives.

Test Plan:
1. Reset, then frame_valid with bytes 0x01..0x0C, status 0x5, freeze=0 -> full=1 next cycle; address 0..11 gives 0x01..0x0C after 1 cycle; address 15 gives 0x25; address 12 gives 0x00.
2. freeze=1, read address 4, inject frame of all 0xAA -> address 4 still shows old value, status bit6 (pending)=1; drop freeze -> next cycle snapshot = 0xAA bytes, pending=0, overrun=1 (prior frame unacked).
3. freeze=1, two frames (0x11.., then 0x22..) -> overrun=1, after unfreeze snapshot bytes = 0x22; ack -> full=0, overrun=0.
4. addr_mode=1, 13 rd_strobe pulses after load -> outputs byte0..byte11, then status, then byte0 again (wrap).
5. ack and frame_valid same cycle with full=1 -> full=1, overrun=0, new data loaded.
6. Assert reset_n=0 while frozen with pending frame -> all outputs 0 next cycle; subsequent unfrozen frame loads normally with overrun=0.
